// File: rtl/data_mem_io.sv
// Data memory with a memory-mapped UART transmitter: 240-byte RAM, a STATUS register
// and a TXDATA register that feeds a 4-entry FIFO drained by an 8N1 serial shifter.
module data_mem_io #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       memWrite,
  input  logic [7:0] toDataMemoryAddress,
  input  logic [7:0] toDataMemory,
  output logic [7:0] fromDataMemory,
  output logic       txd,
  output logic       txBusy
);

  localparam logic [7:0]  ADDR_STATUS = 8'hF0;
  localparam logic [7:0]  ADDR_TXDATA = 8'hF1;
  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  ram [0:239];
  logic [7:0]  fifo [0:3];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        overflow;
  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  logic is_ram, full, empty, wr_txdata, wr_status, push, drop, pop, baud_done;

  assign is_ram    = (toDataMemoryAddress < ADDR_STATUS);
  assign full      = (count == 3'd4);
  assign empty     = (count == 3'd0);
  assign wr_txdata = memWrite && (toDataMemoryAddress == ADDR_TXDATA);
  assign wr_status = memWrite && (toDataMemoryAddress == ADDR_STATUS);
  // Fullness is judged before the edge, so a same-edge pop never rescues a push.
  assign push      = wr_txdata && !full;
  assign drop      = wr_txdata && full;
  assign pop       = (state == IDLE) && !empty;
  assign baud_done = (baud == BAUD_LAST);
  assign txBusy    = (state != IDLE) || !empty;

  always_comb begin
    fromDataMemory = 8'h00;
    if (is_ram)
      fromDataMemory = ram[toDataMemoryAddress];
    else if (toDataMemoryAddress == ADDR_STATUS)
      fromDataMemory = {4'b0000, overflow, txBusy, empty, full};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
      baud     <= 16'd0;
      bit_cnt  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (drop)
        overflow <= 1'b1;
      else if (wr_status)
        overflow <= 1'b0;

      case (state)
        IDLE: begin
          txd     <= 1'b1;
          baud    <= 16'd0;
          bit_cnt <= 3'd0;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= 16'd0;
            bit_cnt <= 3'd0;
            state   <= DATA;
            txd     <= shreg[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shreg[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          if (baud_done) begin
            baud  <= 16'd0;
            state <= IDLE;
          end else begin
            baud <= baud + 16'd1;
          end
        end
      endcase
    end
  end

  // Storage and shift data carry no reset; control above decides when they matter.
  always_ff @(posedge clk) begin
    if (memWrite && is_ram)
      ram[toDataMemoryAddress] <= toDataMemory;
    if (push)
      fifo[wr_ptr] <= toDataMemory;
    if (pop)
      shreg <= fifo[rd_ptr];
    else if ((state == DATA) && baud_done && (bit_cnt != 3'd7))
      shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port memWrite, input, 1, the processor store strobe.
REQ-005 SHALL have port toDataMemoryAddress, input, 8, the processor load/store address.
REQ-006 SHALL have port toDataMemory, input, 8, the processor store data.
REQ-007 SHALL have port fromDataMemory, output, 8, the load data returned to the processor.
REQ-008 SHALL have port txd, output, 1, the serial transmit line, idle high.
REQ-009 SHALL have port txBusy, output, 1, high while a frame is shifting or the FIFO is non-empty.

Function
REQ-010 SHALL decode the address map as follows: 0x00-0xEF RAM (240 bytes); 0xF0 STATUS; 0xF1 TXDATA; 0xF2-0xFF reserved.
REQ-011 SHALL provide combinational reads, so fromDataMemory reflects the addressed location in the same cycle the address is applied; the processor is single-cycle.
REQ-012 SHALL write RAM on the rising edge where memWrite=1 and the address is in the RAM range; no other address alters RAM.
REQ-013 SHALL return STATUS as {4'b0, overflow, txBusy, txEmpty, txFull} (bit0 = txFull).
REQ-014 SHALL read 0x00 at TXDATA and at reserved addresses; writes to reserved addresses SHALL be ignored.
REQ-015 SHALL push toDataMemory into a 4-entry TX FIFO on an edge where memWrite=1, address=0xF1 and the FIFO is not full.
REQ-016 SHALL evaluate fullness before the edge: a push while full is dropped and sets sticky overflow, even if a pop occurs on the same edge.
REQ-017 SHALL clear overflow on any write to 0xF0, regardless of the data value.
REQ-018 SHALL use 2-bit read and write pointers plus a 3-bit count; pointers wrap 3->0, and a simultaneous push and pop leaves the count unchanged.
REQ-019 SHALL implement the transmitter FSM states IDLE, START, DATA, STOP.
REQ-020 IDLE: txd=1; on an edge with the FIFO non-empty, SHALL pop the head entry into the shift register and enter START.
REQ-021 START: SHALL hold txd=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-022 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit counter; after bit 7 it SHALL enter STOP.
REQ-023 STOP: SHALL hold txd=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-024 SHALL allow back-to-back frames: from IDLE with data pending, START begins on the very next edge, so the minimum inter-frame gap is 1 cycle.
REQ-025 SHALL drive txd from a register (glitch-free); the first start bit SHALL appear 2 edges after the push edge (push edge, then pop edge).
REQ-026 SHALL size the baud counter at 16 bits, count 0..CLKS_PER_BIT-1, and reload it on every bit boundary.
REQ-027 SHALL assert txBusy whenever state!=IDLE or count!=0.

Reset
REQ-028 While rst=0, SHALL force: state=IDLE, txd=1, FIFO pointers and count=0, overflow=0, baud and bit counters=0, txBusy=0.
REQ-029 SHALL NOT reset RAM contents; they are undefined until written.
REQ-030 On reset assertion mid-frame, SHALL abort immediately (txd=1 asynchronously) and discard FIFO contents.
REQ-031 On rst release, the first active edge SHALL behave as IDLE with an empty FIFO.

Verification (CLKS_PER_BIT=4)
REQ-032 Write 0x5A to 0x10, then read 0x10 -> 0x5A same cycle; write 0x33 to 0xF5, then read 0xF5 -> 0x00.
REQ-033 Write 0xA5 to 0xF1 -> txd: start 0 (4 cycles), bits 1,0,1,0,0,1,0,1 (4 cycles each), stop 1 (4); start edge 2 cycles after push; txBusy falls after stop.
REQ-034 Five consecutive writes 0x01..0x05 to 0xF1 -> 0x01 popped on edge 2, so 0x05 is accepted; STATUS shows txFull=1 after the fifth push.
REQ-035 Sixth write 0x06 while full -> dropped, STATUS bit3=1; write 0x00 to 0xF0 -> bit3=0; transmitted bytes are exactly 0x01..0x05 with 1-cycle gaps.
REQ-036 Assert rst=0 mid-DATA of 0xFF -> txd=1 immediately, STATUS=0x02 after release, no residual frame.
REQ-037 Push on the same edge the FIFO drains its last entry (count 1->1) -> no byte lost, order preserved.
